// File: rtl/zion_clr_en_pipe_pkg.sv
// Shared types and helpers for the zion_clr_en_pipe register pipeline.
// Holds the per-edge priority encoding and the occupancy counter width.
package zion_clr_en_pipe_pkg;

    // What a stage does on a given clock edge, highest priority first.
    typedef enum logic [1:0] {
        PRI_RST,
        PRI_CLR,
        PRI_EN,
        PRI_HOLD
    } pri_e;

    // Width of an occupancy counter that must represent 0..depth.
    function automatic int CntW(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Resolve which priority level governs the next clock edge.
    function automatic pri_e edge_pri(input logic rst, input logic clr, input logic en);
        if (!rst) return PRI_RST;
        if (clr)  return PRI_CLR;
        if (en)   return PRI_EN;
        return PRI_HOLD;
    endfunction

endpackage

// File: rtl/zion_clr_en_pipe_stage.sv
// One {valid, data} stage of zion_clr_en_pipe.
// Captures {iVld, iDat} when enabled and loaded; an empty capture parks the
// data at INI_DATA so downstream never sees stale payload on an idle stage.
module zion_clr_en_pipe_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iEn,
    input  logic             iClr,
    input  logic             iLd,
    input  logic             iVld,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    output logic [WIDTH-1:0] oDat
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // Next-state selection: flush beats enable, enable+load captures, else hold.
    always_comb begin
        // NOTE: hold values are assigned first so every path drives vld_d/dat_d and no latch is inferred.
        vld_d = vld_q;
        dat_d = dat_q;
        if (iClr) begin
            vld_d = 1'b0;
            dat_d = INI_DATA;
        end else if (iEn && iLd) begin
            vld_d = iVld;
            dat_d = iVld ? iDat : INI_DATA;
        end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all stages sampling pre-edge values, so data shifts one stage per clock.
        if (!rst) begin
            vld_q <= 1'b0;
            dat_q <= INI_DATA;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign oVld = vld_q;
    assign oDat = dat_q;

endmodule

// File: rtl/zion_clr_en_pipe.sv
// Multi-stage clearable/enabled register pipeline with valid/ready handshake.
// Empty stages always accept, so bubbles collapse while the output is stalled;
// iEn=0 freezes everything, iClr flushes every stage like a reset.
// Optional feature macro: ZION_CLR_EN_PIPE_CNT_EN adds the registered oCnt
// occupancy counter; without it the port and counter logic do not exist.
module zion_clr_en_pipe
    import zion_clr_en_pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iEn,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic             oBusy
`ifdef ZION_CLR_EN_PIPE_CNT_EN
    ,
    output logic [CntW(DEPTH)-1:0] oCnt
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("zion_clr_en_pipe: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("zion_clr_en_pipe: WIDTH must be >= 1");
    end

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] in_vld;
    logic [WIDTH-1:0] dat    [DEPTH];
    logic [WIDTH-1:0] in_dat [DEPTH];

    // Advance chain: a stage may capture if it is empty or its successor advances.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = !vld[DEPTH-1] | iRdy;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = !vld[k] | adv[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign in_vld[k] = iVld;
            assign in_dat[k] = iDat;
        end else begin : g_body
            assign in_vld[k] = vld[k-1];
            assign in_dat[k] = dat[k-1];
        end

        zion_clr_en_pipe_stage #(
            .WIDTH   (WIDTH),
            .INI_DATA(INI_DATA)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .iEn (iEn),
            .iClr(iClr),
            .iLd (adv[k]),
            .iVld(in_vld[k]),
            .iDat(in_dat[k]),
            .oVld(vld[k]),
            .oDat(dat[k])
        );
    end

    assign oRdy  = iEn & !iClr & rst & adv[0];
    assign oVld  = vld[DEPTH-1];
    assign oDat  = dat[DEPTH-1];
    assign oBusy = |vld;

`ifdef ZION_CLR_EN_PIPE_CNT_EN
    localparam int CW = CntW(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc, emit;

    assign acc  = iVld & oRdy;
    assign emit = oVld & iRdy & iEn & !iClr;

    // Occupancy next-state: +1 on accept only, -1 on emit only, 0 on flush.
    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (acc && !emit) begin
            cnt_d = cnt_q + 1'b1;
        end else if (emit && !acc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Occupancy register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCnt = cnt_q;

    a_cnt_max: assert property (@(posedge clk) disable iff (!rst) int'(cnt_q) <= DEPTH);
`endif

    pri_e pri;
    assign pri = edge_pri(rst, iClr, iEn);

    a_hold:  assert property (@(posedge clk) pri == PRI_HOLD |=> $stable(oVld) && $stable(oDat));
    a_flush: assert property (@(posedge clk) (pri == PRI_RST || pri == PRI_CLR) |=> !oBusy && oDat == INI_DATA);

endmodule

// File: tb/tb_zion_clr_en_pipe.sv
// Directed bench for zion_clr_en_pipe (WIDTH=32, DEPTH=3, INI_DATA=1).
// Each row drives inputs just after a rising edge and checks outputs at the
// following falling edge against hand-computed values.
module tb_zion_clr_en_pipe;
    import zion_clr_en_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        iEn;
    logic        iClr;
    logic        iVld;
    logic        oRdy;
    logic [31:0] iDat;
    logic        oVld;
    logic        iRdy;
    logic [31:0] oDat;
    logic        oBusy;
`ifdef ZION_CLR_EN_PIPE_CNT_EN
    logic [1:0]  oCnt;
`endif

    int total = 0;
    int bad   = 0;

    // ctl = {rst, iEn, iClr, iVld, iRdy}; ex = {oRdy, oVld, oBusy}
    typedef struct packed {
        logic [4:0]  ctl;
        logic [31:0] dat;
        logic [2:0]  ex;
        logic [31:0] edat;
        logic [1:0]  ecnt;
    } vec_t;

    zion_clr_en_pipe #(
        .WIDTH   (32),
        .DEPTH   (3),
        .INI_DATA(32'h1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .iEn  (iEn),
        .iClr (iClr),
        .iVld (iVld),
        .oRdy (oRdy),
        .iDat (iDat),
        .oVld (oVld),
        .iRdy (iRdy),
        .oDat (oDat),
        .oBusy(oBusy)
`ifdef ZION_CLR_EN_PIPE_CNT_EN
        ,
        .oCnt (oCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        {rst, iEn, iClr, iVld, iRdy} = v.ctl;
        iDat = v.dat;
    endtask

    task automatic test_reset();
        vec_t tbl [7];
        tbl = '{
            '{5'b01001, 32'h0, 3'b000, 32'h1, 2'd0},
            '{5'b01001, 32'h0, 3'b000, 32'h1, 2'd0},
            '{5'b11011, 32'hA, 3'b100, 32'h1, 2'd0},
            '{5'b11001, 32'h0, 3'b101, 32'h1, 2'd1},
            '{5'b11001, 32'h0, 3'b101, 32'h1, 2'd1},
            '{5'b11001, 32'h0, 3'b111, 32'hA, 2'd1},
            '{5'b11001, 32'h0, 3'b100, 32'h1, 2'd0}
        };
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            total++;
            if ({oRdy, oVld, oBusy} !== tbl[i].ex) begin
                bad++;
                $display("FAIL reset row %0d (%s): rdy/vld/busy got %b want %b", i,
                         edge_pri(rst, iClr, iEn).name(), {oRdy, oVld, oBusy}, tbl[i].ex);
            end
            total++;
            if (oDat !== tbl[i].edat) begin
                bad++;
                $display("FAIL reset row %0d: oDat got %h want %h", i, oDat, tbl[i].edat);
            end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
            total++;
            if (oCnt !== tbl[i].ecnt) begin
                bad++;
                $display("FAIL reset row %0d: oCnt got %0d want %0d", i, oCnt, tbl[i].ecnt);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_streaming();
        vec_t tbl [8];
        tbl = '{
            '{5'b11011, 32'hA, 3'b100, 32'h1, 2'd0},
            '{5'b11011, 32'hB, 3'b101, 32'h1, 2'd1},
            '{5'b11011, 32'hC, 3'b101, 32'h1, 2'd2},
            '{5'b11011, 32'hD, 3'b111, 32'hA, 2'd3},
            '{5'b11001, 32'h0, 3'b111, 32'hB, 2'd3},
            '{5'b11001, 32'h0, 3'b111, 32'hC, 2'd2},
            '{5'b11001, 32'h0, 3'b111, 32'hD, 2'd1},
            '{5'b11001, 32'h0, 3'b100, 32'h1, 2'd0}
        };
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            total++;
            if ({oRdy, oVld, oBusy} !== tbl[i].ex) begin
                bad++;
                $display("FAIL streaming row %0d (%s): rdy/vld/busy got %b want %b", i,
                         edge_pri(rst, iClr, iEn).name(), {oRdy, oVld, oBusy}, tbl[i].ex);
            end
            total++;
            if (oDat !== tbl[i].edat) begin
                bad++;
                $display("FAIL streaming row %0d: oDat got %h want %h", i, oDat, tbl[i].edat);
            end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
            total++;
            if (oCnt !== tbl[i].ecnt) begin
                bad++;
                $display("FAIL streaming row %0d: oCnt got %0d want %0d", i, oCnt, tbl[i].ecnt);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        vec_t tbl [11];
        tbl = '{
            '{5'b11010, 32'h10, 3'b100, 32'h1,  2'd0},
            '{5'b11010, 32'h11, 3'b101, 32'h1,  2'd1},
            '{5'b11010, 32'h12, 3'b101, 32'h1,  2'd2},
            '{5'b11010, 32'h13, 3'b011, 32'h10, 2'd3},
            '{5'b11010, 32'h13, 3'b011, 32'h10, 2'd3},
            '{5'b11011, 32'h13, 3'b111, 32'h10, 2'd3},
            '{5'b11011, 32'h14, 3'b111, 32'h11, 2'd3},
            '{5'b11001, 32'h0,  3'b111, 32'h12, 2'd3},
            '{5'b11001, 32'h0,  3'b111, 32'h13, 2'd2},
            '{5'b11001, 32'h0,  3'b111, 32'h14, 2'd1},
            '{5'b11001, 32'h0,  3'b100, 32'h1,  2'd0}
        };
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            total++;
            if ({oRdy, oVld, oBusy} !== tbl[i].ex) begin
                bad++;
                $display("FAIL backpressure row %0d (%s): rdy/vld/busy got %b want %b", i,
                         edge_pri(rst, iClr, iEn).name(), {oRdy, oVld, oBusy}, tbl[i].ex);
            end
            total++;
            if (oDat !== tbl[i].edat) begin
                bad++;
                $display("FAIL backpressure row %0d: oDat got %h want %h", i, oDat, tbl[i].edat);
            end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
            total++;
            if (oCnt !== tbl[i].ecnt) begin
                bad++;
                $display("FAIL backpressure row %0d: oCnt got %0d want %0d", i, oCnt, tbl[i].ecnt);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_bubble_collapse();
        vec_t tbl [12];
        tbl = '{
            '{5'b11010, 32'hA, 3'b100, 32'h1, 2'd0},
            '{5'b11000, 32'h0, 3'b101, 32'h1, 2'd1},
            '{5'b11010, 32'hB, 3'b101, 32'h1, 2'd1},
            '{5'b11000, 32'h0, 3'b111, 32'hA, 2'd2},
            '{5'b11000, 32'h0, 3'b111, 32'hA, 2'd2},
            '{5'b11010, 32'hC, 3'b111, 32'hA, 2'd2},
            '{5'b11010, 32'hE, 3'b011, 32'hA, 2'd3},
            '{5'b11011, 32'hE, 3'b111, 32'hA, 2'd3},
            '{5'b11001, 32'h0, 3'b111, 32'hB, 2'd3},
            '{5'b11001, 32'h0, 3'b111, 32'hC, 2'd2},
            '{5'b11001, 32'h0, 3'b111, 32'hE, 2'd1},
            '{5'b11001, 32'h0, 3'b100, 32'h1, 2'd0}
        };
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            total++;
            if ({oRdy, oVld, oBusy} !== tbl[i].ex) begin
                bad++;
                $display("FAIL bubble row %0d (%s): rdy/vld/busy got %b want %b", i,
                         edge_pri(rst, iClr, iEn).name(), {oRdy, oVld, oBusy}, tbl[i].ex);
            end
            total++;
            if (oDat !== tbl[i].edat) begin
                bad++;
                $display("FAIL bubble row %0d: oDat got %h want %h", i, oDat, tbl[i].edat);
            end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
            total++;
            if (oCnt !== tbl[i].ecnt) begin
                bad++;
                $display("FAIL bubble row %0d: oCnt got %0d want %0d", i, oCnt, tbl[i].ecnt);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        vec_t tbl [11];
        tbl = '{
            '{5'b11010, 32'h21, 3'b100, 32'h1,  2'd0},
            '{5'b11010, 32'h22, 3'b101, 32'h1,  2'd1},
            '{5'b11010, 32'h23, 3'b101, 32'h1,  2'd2},
            '{5'b10011, 32'h24, 3'b011, 32'h21, 2'd3},
            '{5'b10011, 32'h24, 3'b011, 32'h21, 2'd3},
            '{5'b10011, 32'h24, 3'b011, 32'h21, 2'd3},
            '{5'b11011, 32'h24, 3'b111, 32'h21, 2'd3},
            '{5'b11001, 32'h0,  3'b111, 32'h22, 2'd3},
            '{5'b11001, 32'h0,  3'b111, 32'h23, 2'd2},
            '{5'b11001, 32'h0,  3'b111, 32'h24, 2'd1},
            '{5'b11001, 32'h0,  3'b100, 32'h1,  2'd0}
        };
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            total++;
            if ({oRdy, oVld, oBusy} !== tbl[i].ex) begin
                bad++;
                $display("FAIL stall row %0d (%s): rdy/vld/busy got %b want %b", i,
                         edge_pri(rst, iClr, iEn).name(), {oRdy, oVld, oBusy}, tbl[i].ex);
            end
            total++;
            if (oDat !== tbl[i].edat) begin
                bad++;
                $display("FAIL stall row %0d: oDat got %h want %h", i, oDat, tbl[i].edat);
            end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
            total++;
            if (oCnt !== tbl[i].ecnt) begin
                bad++;
                $display("FAIL stall row %0d: oCnt got %0d want %0d", i, oCnt, tbl[i].ecnt);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        vec_t tbl [8];
        tbl = '{
            '{5'b11010, 32'h31, 3'b100, 32'h1,  2'd0},
            '{5'b11010, 32'h32, 3'b101, 32'h1,  2'd1},
            '{5'b11010, 32'h33, 3'b101, 32'h1,  2'd2},
            '{5'b10110, 32'h34, 3'b011, 32'h31, 2'd3},
            '{5'b11001, 32'h0,  3'b100, 32'h1,  2'd0},
            '{5'b11001, 32'h0,  3'b100, 32'h1,  2'd0},
            '{5'b11001, 32'h0,  3'b100, 32'h1,  2'd0},
            '{5'b11001, 32'h0,  3'b100, 32'h1,  2'd0}
        };
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            total++;
            if ({oRdy, oVld, oBusy} !== tbl[i].ex) begin
                bad++;
                $display("FAIL flush row %0d (%s): rdy/vld/busy got %b want %b", i,
                         edge_pri(rst, iClr, iEn).name(), {oRdy, oVld, oBusy}, tbl[i].ex);
            end
            total++;
            if (oDat !== tbl[i].edat) begin
                bad++;
                $display("FAIL flush row %0d: oDat got %h want %h", i, oDat, tbl[i].edat);
            end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
            total++;
            if (oCnt !== tbl[i].ecnt) begin
                bad++;
                $display("FAIL flush row %0d: oCnt got %0d want %0d", i, oCnt, tbl[i].ecnt);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midstream();
        vec_t tbl [7];
        tbl = '{
            '{5'b11011, 32'h41, 3'b100, 32'h1, 2'd0},
            '{5'b11011, 32'h42, 3'b101, 32'h1, 2'd1},
            '{5'b01011, 32'h43, 3'b001, 32'h1, 2'd2},
            '{5'b11001, 32'h0,  3'b100, 32'h1, 2'd0},
            '{5'b11001, 32'h0,  3'b100, 32'h1, 2'd0},
            '{5'b11001, 32'h0,  3'b100, 32'h1, 2'd0},
            '{5'b11001, 32'h0,  3'b100, 32'h1, 2'd0}
        };
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            total++;
            if ({oRdy, oVld, oBusy} !== tbl[i].ex) begin
                bad++;
                $display("FAIL midreset row %0d (%s): rdy/vld/busy got %b want %b", i,
                         edge_pri(rst, iClr, iEn).name(), {oRdy, oVld, oBusy}, tbl[i].ex);
            end
            total++;
            if (oDat !== tbl[i].edat) begin
                bad++;
                $display("FAIL midreset row %0d: oDat got %h want %h", i, oDat, tbl[i].edat);
            end
`ifdef ZION_CLR_EN_PIPE_CNT_EN
            total++;
            if (oCnt !== tbl[i].ecnt) begin
                bad++;
                $display("FAIL midreset row %0d: oCnt got %0d want %0d", i, oCnt, tbl[i].ecnt);
            end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst  = 1'b0;
        iEn  = 1'b0;
        iClr = 1'b0;
        iVld = 1'b0;
        iRdy = 1'b0;
        iDat = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_stall();
        test_flush();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
